ps2_key_event_decoder: RTL and testbench

- Turns the PS/2 scan-code byte stream from the keyboard frame receiver into the key-state interface consumed by the game logic: a 512-bit key_down map, a 9-bit last_change code and a one-cycle key_valid strobe.
- Decodes PS/2 Set-2 prefixes: E0 for extended keys, F0 for break (key release) and the E1 Pause sequence.
- Sits between the PS/2 receiver and the typing/countdown logic.

---
 rtl/ps2_key_event_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 scan-code decoder: E0/F0/E1 prefix handling into a 512-bit key map and event strobe.
// Optional REPEAT_FILTER_EN suppresses the event for a make of a key that is already held.
module ps2_key_event_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned E1_SKIP        = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         frame_err,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         seq_busy
);

  localparam int unsigned TmoW  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SkipW = ($clog2(E1_SKIP + 1) > 0) ? $clog2(E1_SKIP + 1) : 1;

  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [SkipW-1:0] SkipLoad = SkipW'(E1_SKIP);
  localparam logic [SkipW-1:0] SkipOne  = SkipW'(1);

  localparam logic [7:0] ByteExt   = 8'hE0;
  localparam logic [7:0] ByteBrk   = 8'hF0;
  localparam logic [7:0] BytePause = 8'hE1;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StSkip
  } state_e;

  state_e           state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic [511:0]     key_down_q, key_down_d;
  logic [8:0]       last_q, last_d;
  logic             kv_q, kv_d;
  logic             busy_q;

  logic             ignored;
  logic             ev_fire;
  logic             ev_make;
  logic             ev_ext;
  logic [8:0]       ev_code;
  logic             ev_suppress;

  // Keyboard status/acknowledge bytes that carry no key information.
  always_comb begin
    unique case (byte_in)
      8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF: ignored = 1'b1;
      default:                                  ignored = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    ev_fire = 1'b0;
    ev_make = 1'b0;
    ev_ext  = 1'b0;

    if (frame_err) begin
      state_d = StIdle;
      skip_d  = '0;
      tmo_d   = '0;
    end else if (byte_valid) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (byte_in == ByteExt) begin
            state_d = StExt;
          end else if (byte_in == ByteBrk) begin
            state_d = StBrk;
          end else if (byte_in == BytePause) begin
            state_d = StSkip;
            skip_d  = SkipLoad;
          end else if (!ignored) begin
            ev_fire = 1'b1;
            ev_make = 1'b1;
          end
        end
        StExt: begin
          if (byte_in == ByteBrk) begin
            state_d = StExtBrk;
          end else if (byte_in != ByteExt) begin
            ev_fire = 1'b1;
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          ev_fire = 1'b1;
          state_d = StIdle;
        end
        StExtBrk: begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
          state_d = StIdle;
        end
        StSkip: begin
          if (skip_q <= SkipOne) begin
            skip_d  = '0;
            state_d = StIdle;
          end else begin
            skip_d = skip_q - SkipOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Counter stops at the abandon point, so it can never wrap.
      if (tmo_q >= TmoLast) begin
        state_d = StIdle;
        tmo_d   = '0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign ev_code = {ev_ext, byte_in};

`ifdef REPEAT_FILTER_EN
  assign ev_suppress = ev_make & key_down_q[ev_code];
`else
  assign ev_suppress = 1'b0;
`endif

  always_comb begin
    key_down_d = key_down_q;
    last_d     = last_q;
    kv_d       = 1'b0;
    if (ev_fire && !ev_suppress) begin
      key_down_d[ev_code] = ev_make;
      last_d              = ev_code;
      kv_d                = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      skip_q     <= '0;
      key_down_q <= '0;
      last_q     <= '0;
      kv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      skip_q     <= skip_d;
      key_down_q <= key_down_d;
      last_q     <= last_d;
      kv_q       <= kv_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_q;
  assign key_valid   = kv_q;
  assign seq_busy    = busy_q;

`ifndef SYNTHESIS
  key_valid_one_cycle: assert property (@(posedge clk) disable iff (!rst)
    key_valid |=> !key_valid);
  busy_tracks_state: assert property (@(posedge clk) disable iff (!rst)
    seq_busy == (state_q != StIdle));
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Randomized bench for ps2_key_event_decoder against a byte-queue reference model,
// plus directed sequences with hand-computed expectations.
module tb_ps2_key_event_decoder;

  localparam int unsigned Tmo  = 40;
  localparam int unsigned Skip = 7;
`ifdef REPEAT_FILTER_EN
  localparam bit Filter = 1'b1;
`else
  localparam bit Filter = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         frame_err = 1'b0;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         seq_busy;

  ps2_key_event_decoder #(
    .TIMEOUT_CYCLES(Tmo),
    .E1_SKIP       (Skip)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid),
    .seq_busy   (seq_busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the unfinished sequence are kept in a queue.
  logic [511:0] m_down;
  logic [8:0]   m_last;
  logic         m_kv;
  logic         m_busy;
  logic [7:0]   m_seq[$];
  int           m_quiet;

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;
  int pulses = 0;

  function automatic bit is_ignored(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    m_down  = '0;
    m_last  = '0;
    m_kv    = 1'b0;
    m_seq.delete();
    m_quiet = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic       ext;
    logic       brk;
    logic [8:0] idx;
    m_seq.push_back(b);
    m_quiet = 0;
    if (m_seq[0] == 8'hE1) begin
      if (m_seq.size() == int'(Skip) + 1) m_seq.delete();
      return;
    end
    if (m_seq.size() == 1 && is_ignored(b)) begin
      m_seq.delete();
      return;
    end
    ext = 1'b0;
    brk = 1'b0;
    for (int i = 0; i < m_seq.size() - 1; i++) begin
      if (m_seq[i] == 8'hE0) ext = 1'b1;
      if (m_seq[i] == 8'hF0) brk = 1'b1;
    end
    if (!brk && (b == 8'hE0 || b == 8'hF0)) return;
    idx = {ext, b};
    m_seq.delete();
    if (brk) begin
      m_down[idx] = 1'b0;
      m_last      = idx;
      m_kv        = 1'b1;
    end else if (!(Filter && m_down[idx])) begin
      m_down[idx] = 1'b1;
      m_last      = idx;
      m_kv        = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    checks++;
    if (key_down !== m_down) begin
      miscompares++;
      $display("FAIL key_down t=%0t got=%h exp=%h", $time, key_down, m_down);
    end
    chk("last_change", 32'(last_change), 32'(m_last));
    chk("key_valid", 32'(key_valid), 32'(m_kv));
    chk("seq_busy", 32'(seq_busy), 32'(m_busy));
  endtask

  // One clock: drive on the falling edge, step the model, check after the rising edge.
  task automatic cycle(input logic [7:0] b, input logic v, input logic fe, input logic r);
    @(negedge clk);
    rst        = r;
    byte_in    = b;
    byte_valid = v;
    frame_err  = fe;
    m_kv       = 1'b0;
    if (!r) begin
      model_reset();
    end else if (fe) begin
      m_seq.delete();
      m_quiet = 0;
    end else if (v) begin
      model_byte(b);
    end else if (m_seq.size() != 0) begin
      m_quiet++;
      if (m_quiet >= int'(Tmo)) begin
        m_seq.delete();
        m_quiet = 0;
      end
    end
    m_busy = (m_seq.size() != 0);
    @(posedge clk);
    #1;
    vectors++;
    compare();
    if (key_valid) pulses++;
  endtask

  task automatic idle();
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(b, 1'b1, 1'b0, 1'b1);
    idle();
  endtask

  logic [7:0] rb;
  int         r;
  int         gap;
  logic       fe;

  initial begin
    model_reset();
    m_busy = 1'b0;

    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_key_down_any", 32'(|key_down), 0);
    chk("rst_last_change", 32'(last_change), 0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_seq_busy", 32'(seq_busy), 0);
    idle();

    // Plain make.
    cycle(8'h1C, 1'b1, 1'b0, 1'b1);
    chk("make1c_kv", 32'(key_valid), 1);
    chk("make1c_bit", 32'(key_down[9'h01C]), 1);
    chk("make1c_last", 32'(last_change), 32'h01C);
    chk("make1c_busy", 32'(seq_busy), 0);
    idle();
    chk("make1c_kv_drop", 32'(key_valid), 0);

    // Plain break.
    pulses = 0;
    send(8'hF0);
    chk("brk_prefix_busy", 32'(seq_busy), 1);
    chk("brk_prefix_pulses", 32'(pulses), 0);
    send(8'h1C);
    chk("brk1c_bit", 32'(key_down[9'h01C]), 0);
    chk("brk1c_last", 32'(last_change), 32'h01C);
    chk("brk1c_pulses", 32'(pulses), 1);

    // Extended make then extended break.
    pulses = 0;
    send(8'hE0);
    send(8'h75);
    chk("ext_make_bit", 32'(key_down[9'h175]), 1);
    chk("ext_make_last", 32'(last_change), 32'h175);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_brk_bit", 32'(key_down[9'h175]), 0);
    chk("ext_brk_last", 32'(last_change), 32'h175);
    chk("ext_pulses", 32'(pulses), 2);

    // Pause sequence produces nothing.
    pulses = 0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_busy_7", 32'(seq_busy), 1);
    send(8'h77);
    chk("pause_busy_8", 32'(seq_busy), 0);
    chk("pause_pulses", 32'(pulses), 0);
    chk("pause_key_down_any", 32'(|key_down), 0);
    send(8'h29);
    chk("after_pause_bit", 32'(key_down[9'h029]), 1);

    // Abandoned E0 prefix.
    cycle(8'hE0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(Tmo) - 1; i++) idle();
    chk("tmo_busy_before", 32'(seq_busy), 1);
    idle();
    chk("tmo_busy_after", 32'(seq_busy), 0);
    send(8'h29);
    chk("tmo_last", 32'(last_change), 32'h029);

    // Typematic repeat and frame error.
    pulses = 0;
    send(8'h1C);
    send(8'h1C);
    chk("repeat_pulses", 32'(pulses), Filter ? 1 : 2);
    cycle(8'hF0, 1'b1, 1'b1, 1'b1);
    chk("ferr_busy", 32'(seq_busy), 0);
    idle();
    send(8'h1C);
    chk("ferr_bit", 32'(key_down[9'h01C]), 1);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12)      rb = 8'hE0;
      else if (r < 26) rb = 8'hF0;
      else if (r < 29) rb = 8'hE1;
      else if (r < 33) rb = 8'hFA;
      else if (r < 85) rb = 8'($urandom_range(1, 12));
      else             rb = 8'($urandom);
      fe = ($urandom_range(0, 49) == 0);
      cycle(rb, 1'b1, fe, 1'b1);
      r = int'($urandom_range(0, 59));
      if (r == 0)      gap = int'(Tmo) - 1;
      else if (r == 1) gap = int'(Tmo);
      else if (r == 2) gap = int'(Tmo) + 3;
      else             gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 99) == 0) cycle(8'h00, 1'b0, 1'b1, 1'b1);
        else                            idle();
      end
      if ($urandom_range(0, 299) == 0) begin
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
